// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO, with MF/MT moves and EX stall
// Ports: clk, rst (async active-high); start, funct, a, b (EX-stage instruction and operands);
//        busy (iteration in progress), done (HI/LO just written), stall (hold IF/ID/EX),
//        result (HI/LO for MFHI/MFLO, else 0), hi, lo, dz_err (divide-by-zero pulse).
// Option: define MULDIV_DIVZERO_TRAP_EN to trap DIV/DIVU by zero instead of iterating.
module ex_muldiv_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [5:0]   funct,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         stall,
    output logic [W-1:0] result,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         dz_err
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_n;
    logic [CW-1:0] ctr;
    logic [W:0] acc, acc_n, sum, sh, diff;
    logic [W-1:0] q, q_n, mb, ma, mbv, res_hi, res_lo;
    logic [2*W-1:0] prod;
    logic is_div, sa, sb, dz, dz_go, is_md, is_mv, go, sgn;
    assign is_md = funct[5:2] == 4'b0110;
    assign is_mv = funct[5:2] == 4'b0100;
    assign sgn = ~funct[0];
    assign go = start && is_md && state == IDLE;
    assign ma = (sgn && a[W-1]) ? -a : a;
    assign mbv = (sgn && b[W-1]) ? -b : b;
`ifdef MULDIV_DIVZERO_TRAP_EN
    assign dz_go = funct[1] && b == '0;
`else
    assign dz_go = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb
        state_n = state == IDLE ? (go ? (dz_go ? FIN : RUN) : IDLE) :
                  state == RUN  ? (ctr == CW'(W-1) ? FIN : RUN) : IDLE;
    always_comb begin
        busy = state != IDLE;
        stall = start && busy && (is_md || is_mv);
        result = funct == 6'b010000 ? hi : funct == 6'b010010 ? lo : '0;
    end
    // acc:q is the product shift register for mul and remainder:quotient for div
    always_comb begin
        sum = acc + (q[0] ? {1'b0, mb} : '0);
        sh = {acc[W-1:0], q[W-1]};
        diff = sh - {1'b0, mb};
        acc_n = is_div ? (diff[W] ? sh : diff) : {1'b0, sum[W:1]};
        q_n = is_div ? {q[W-2:0], ~diff[W]} : {sum[0], q[W-1:1]};
        prod = (sa ^ sb) ? -{acc[W-1:0], q} : {acc[W-1:0], q};
        res_hi = is_div ? (sa ? -acc[W-1:0] : acc[W-1:0]) : prod[2*W-1:W];
        res_lo = is_div ? ((sa ^ sb) ? -q : q) : prod[W-1:0];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hi <= '0;
            lo <= '0;
            acc <= '0;
            q <= '0;
            mb <= '0;
            ctr <= '0;
            is_div <= 1'b0;
            sa <= 1'b0;
            sb <= 1'b0;
            dz <= 1'b0;
            done <= 1'b0;
            dz_err <= 1'b0;
        end else begin
            done <= state == FIN;
            dz_err <= state == FIN && dz;
            if (go) begin
                acc <= '0;
                q <= ma;
                mb <= mbv;
                ctr <= '0;
                is_div <= funct[1];
                sa <= sgn && a[W-1];
                sb <= sgn && b[W-1];
                dz <= dz_go;
            end else if (state == RUN) begin
                acc <= acc_n;
                q <= q_n;
                ctr <= ctr + 1'b1;
            end else if (state == FIN) begin
                if (!dz) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end else if (start && is_mv && funct[0]) begin
                if (funct[1]) lo <= a;
                else hi <= a;
            end
        end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and randomized checks of ex_muldiv_unit against a cycle-level behavioural model
module tb_ex_muldiv_unit;
    localparam int W = 32;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1a, DIVU = 6'h1b;
    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13, ADD = 6'h20;
    logic clk = 0, rst = 1, start = 0;
    logic [5:0] funct = ADD;
    logic [31:0] a = 0, b = 0;
    logic busy, done, stall, dz_err;
    logic [31:0] result, hi, lo;
    int checks = 0, errors = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic [63:0] m_res = 0;
    int m_left = 0;
    logic m_done = 0, m_dz = 0, m_ndz = 0;

    ex_muldiv_unit #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
        .busy(busy), .done(done), .stall(stall), .result(result),
        .hi(hi), .lo(lo), .dz_err(dz_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    // {hi,lo} from plain arithmetic; SV signed division already truncates toward zero
    function automatic logic [63:0] calc(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, qq, rr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f)
            MULT: p = 64'(sx * sy);
            MULTU: p = {32'd0, x} * {32'd0, y};
            DIVU: p = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            default:
                if (y == 0) p = {x, x[31] ? 32'd1 : 32'hFFFFFFFF};
                else begin
                    qq = sx / sy;
                    rr = sx % sy;
                    p = {rr[31:0], qq[31:0]};
                end
        endcase
        return p;
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) begin
            m_hi <= 0;
            m_lo <= 0;
            m_left <= 0;
            m_done <= 0;
            m_dz <= 0;
            m_ndz <= 0;
        end else begin
            m_done <= m_left == 1;
            m_dz <= m_left == 1 && m_ndz;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1 && !m_ndz) begin
                    m_hi <= m_res[63:32];
                    m_lo <= m_res[31:0];
                end
            end else if (start) begin
                if (funct inside {MULT, MULTU, DIV, DIVU}) begin
                    m_res <= calc(funct, a, b);
                    m_left <= W + 1;
                    m_ndz <= 0;
`ifdef MULDIV_DIVZERO_TRAP_EN
                    if (funct inside {DIV, DIVU} && b == 0) begin
                        m_left <= 1;
                        m_ndz <= 1;
                    end
`endif
                end else if (funct == MTHI) m_hi <= a;
                else if (funct == MTLO) m_lo <= a;
            end
        end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("dz_err", {31'd0, dz_err}, {31'd0, m_dz});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("stall", {31'd0, stall}, {31'd0, start && m_left > 0 &&
            funct inside {MULT, MULTU, DIV, DIVU, MFHI, MTHI, MFLO, MTLO}});
        chk("result", result, funct == MFHI ? m_hi : funct == MFLO ? m_lo : 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        start = 1;
        funct = f;
        a = x;
        b = y;
        tick();
        start = 0;
        funct = ADD;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk("done_timeout", 32'(n), 32'd0);
    endtask

    function automatic logic [31:0] rop();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] ftab [13] = '{MULT, MULTU, DIV, DIVU, MFHI, MTHI, MFLO, MTLO, ADD, 6'h21, 6'h2a, 6'h00, 6'h1c};

    initial begin
        int n, k;
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        tick();
        rst = 0;
        tick();
        issue(MULT, 32'hFFFFFFFD, 32'h00000007);
        wait_done(n);
        chk("t1_lat", 32'(n), 32'd33);
        chk("t1_hi", hi, 32'hFFFFFFFF);
        chk("t1_lo", lo, 32'hFFFFFFEB);
        start = 1;
        funct = MFLO;
        #1 chk("t1_mflo", result, 32'hFFFFFFEB);
        tick();
        start = 0;
        funct = ADD;
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n);
        chk("t2_lat", 32'(n), 32'd33);
        chk("t2_hi", hi, 32'hFFFFFFFE);
        chk("t2_lo", lo, 32'h00000001);
        issue(DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(n);
        chk("t3_div_lo", lo, 32'hFFFFFFFD);
        chk("t3_div_hi", hi, 32'hFFFFFFFF);
        issue(DIVU, 32'd100, 32'd7);
        repeat (4) tick();
        start = 1;
        funct = ADD;
        #1 chk("t4_add_stall", {31'd0, stall}, 32'd0);
        tick();
        funct = MFLO;
        #1;
        k = 0;
        while (busy && k < 60) begin
            chk("t4_mf_stall", {31'd0, stall}, 32'd1);
            tick();
            k++;
        end
        chk("t4_result", result, 32'd14);
        chk("t4_hi", hi, 32'd2);
        chk("t4_stall_off", {31'd0, stall}, 32'd0);
        start = 0;
        funct = ADD;
        tick();
        issue(MTHI, 32'h12345678, 32'd0);
        chk("t5_mthi", hi, 32'h12345678);
        chk("t5_mthi_busy", {31'd0, busy}, 32'd0);
        issue(DIVU, 32'd9, 32'd0);
        wait_done(n);
`ifdef MULDIV_DIVZERO_TRAP_EN
        chk("t5_lat", 32'(n), 32'd1);
        chk("t5_dz", {31'd0, dz_err}, 32'd1);
        chk("t5_hi", hi, 32'h12345678);
`else
        chk("t5_lat", 32'(n), 32'd33);
        chk("t5_dz", {31'd0, dz_err}, 32'd0);
        chk("t5_hi", hi, 32'd9);
        chk("t5_lo", lo, 32'hFFFFFFFF);
`endif
        issue(MULT, 32'h00001234, 32'h00005678);
        repeat (9) tick();
        rst = 1;
        #1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_hi", hi, 32'd0);
        chk("t6_lo", lo, 32'd0);
        tick();
        rst = 0;
        k = 0;
        repeat (35) begin
            if (done) k++;
            tick();
        end
        chk("t6_nodone", 32'(k), 32'd0);
        issue(MULTU, 32'd3, 32'd5);
        wait_done(n);
        chk("t6_lat", 32'(n), 32'd33);
        chk("t6_lo", lo, 32'd15);
        chk("t6_hi2", hi, 32'd0);
        repeat (3000) begin
            start = $urandom_range(0, 3) == 0;
            funct = ftab[$urandom_range(0, 12)];
            a = rop();
            b = rop();
            tick();
        end
        start = 0;
        funct = ADD;
        repeat (40) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
